uart_rx_byte: RTL and testbench

//  Serial-to-byte UART receiver: 8N1, LSB first. Upstream stage of the packet parser (Serial2CMD).

---
 rtl/uart_rx_byte.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first UART receiver with a 2-flop input synchronizer and a byte-wide output strobe.
// Optional build macro UART_RX_MAJORITY_EN: each sample becomes a 2-of-3 vote over three adjacent clocks.
module uart_rx_byte #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       iCLK,
  input  logic       iRst_n,
  input  logic       iRx,
  output logic [7:0] oData,
  output logic       oRx_ready,
  output logic       oFrame_err,
  output logic       oBusy,
  output logic [2:0] o_dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID   = CLKS_PER_BIT / 2;

  // The vote needs the clock after the sampling point, so every decision moves one clock later.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(MID);
`else
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(MID - 1);
`endif
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_cfg
      $error("uart_rx_byte: CLKS_PER_BIT must be >= 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shreg;
  logic [7:0]       r_data;
  logic             r_rx_ready;
  logic             r_frame_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [7:0]       w_shreg_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_rx_ready_nxt;
  logic             w_frame_err_nxt;
  logic             w_rx_s;
  logic             w_sample;

  assign w_rx_s = r_sync2;

  always_ff @(posedge iCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= iRx;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_rx_d1;
  logic r_rx_d2;

  always_ff @(posedge iCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_rx_d1 <= 1'b1;
      r_rx_d2 <= 1'b1;
    end else begin
      r_rx_d1 <= w_rx_s;
      r_rx_d2 <= r_rx_d1;
    end
  end

  // r_rx_d1 is the nominal sampling point; w_rx_s and r_rx_d2 are its neighbours.
  assign w_sample = (w_rx_s & r_rx_d1) | (w_rx_s & r_rx_d2) | (r_rx_d1 & r_rx_d2);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge iCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_rx_ready  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      r_data      <= w_data_nxt;
      r_rx_ready  <= w_rx_ready_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt + CNT_W'(1);
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shreg_nxt     = r_shreg;
    w_data_nxt      = r_data;
    w_rx_ready_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_clk_cnt == START_LAST) begin
          w_clk_cnt_nxt = '0;
          if (w_sample) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
      end
      S_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_shreg_nxt   = {w_sample, r_shreg[7:1]};
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (w_sample) begin
            w_data_nxt     = r_shreg;
            w_rx_ready_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end
      end
      // A line held low after a bad stop bit must not look like a new start bit.
      S_BREAK: begin
        w_clk_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_clk_cnt_nxt = '0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  assign oData       = r_data;
  assign oRx_ready   = r_rx_ready;
  assign oFrame_err  = r_frame_err;
  assign oBusy       = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 10 clocks per bit (CLK_HZ=50M, BAUD=5M).
module tb_uart_rx_byte;

  localparam int CPB = 10;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h55;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h51;
`endif

  logic       iCLK = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iRx = 1'b1;
  logic [7:0] oData;
  logic       oRx_ready;
  logic       oFrame_err;
  logic       oBusy;
  logic [2:0] o_dbg_state;

  uart_rx_byte #(
    .CLK_HZ(50_000_000),
    .BAUD  (5_000_000)
  ) dut (
    .iCLK       (iCLK),
    .iRst_n     (iRst_n),
    .iRx        (iRx),
    .oData      (oData),
    .oRx_ready  (oRx_ready),
    .oFrame_err (oFrame_err),
    .oBusy      (oBusy),
    .o_dbg_state(o_dbg_state)
  );

  // clock
  always #5 iCLK = ~iCLK;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         strobe_cyc[$];
  int         rx_cnt = 0;
  int         fe_cnt = 0;
  int         rx_extra = 0;
  int         viol = 0;
  int         cyc = 0;
  bit         rec = 1'b0;
  logic       prev_rdy = 1'b0;
  logic       prev_fe = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every good-byte strobe pops the expected queue
  always @(negedge iCLK) begin
    cyc++;
    if (iRst_n) begin
      if (oRx_ready && oFrame_err) viol++;
      if (oRx_ready && prev_rdy) viol++;
      if (oFrame_err && prev_fe) viol++;
      if (oRx_ready) begin
        rx_cnt++;
        if (rec) strobe_cyc.push_back(cyc);
        if (exp_q.size() > 0) check_eq("rx_byte", {24'h0, oData}, {24'h0, exp_q.pop_front()});
        else rx_extra++;
      end
      if (oFrame_err) fe_cnt++;
    end
    prev_rdy = oRx_ready;
    prev_fe  = oFrame_err;
  end

  // driver tasks, always entered on a falling clock edge
  task automatic send_bit(input logic b);
    iRx = b;
    repeat (CPB) @(negedge iCLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1_bytes[3];
    logic [7:0] t2_bytes[9];
    logic [7:0] c1;
    logic [7:0] g;
    int         base_rx;
    int         base_fe;

    t1_bytes = '{8'hFF, 8'hFA, 8'h1B};
    t2_bytes = '{8'hFF, 8'hFA, 8'h16, 8'h96, 8'h2D, 8'hE0, 8'h01, 8'h5E, 8'h12};
    c1 = 8'hC1;
    g  = 8'h55;

    // reset state
    iRst_n = 1'b0;
    iRx    = 1'b1;
    repeat (3) @(negedge iCLK);
    check_eq("rst_data", {24'h0, oData}, 32'h00);
    check_eq("rst_ready", {31'h0, oRx_ready}, 32'h0);
    check_eq("rst_ferr", {31'h0, oFrame_err}, 32'h0);
    check_eq("rst_busy", {31'h0, oBusy}, 32'h0);
    check_eq("rst_state", {29'h0, o_dbg_state}, 32'h0);
    iRst_n = 1'b1;
    repeat (5) @(negedge iCLK);

    // 1: three bytes with one idle bit between them
    base_rx = rx_cnt;
    foreach (t1_bytes[i]) begin
      exp_q.push_back(t1_bytes[i]);
      send_byte(t1_bytes[i], 1'b1);
      send_bit(1'b1);
    end
    repeat (CPB) @(negedge iCLK);
    check_eq("t1_count", rx_cnt - base_rx, 3);
    check_eq("t1_drained", exp_q.size(), 0);
    check_eq("t1_no_ferr", fe_cnt, 0);
    check_eq("t1_last", {24'h0, oData}, 32'h1B);

    // 2: nine bytes back-to-back
    strobe_cyc.delete();
    rec = 1'b1;
    foreach (t2_bytes[i]) begin
      exp_q.push_back(t2_bytes[i]);
      send_byte(t2_bytes[i], 1'b1);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    rec = 1'b0;
    check_eq("t2_count", strobe_cyc.size(), 9);
    check_eq("t2_drained", exp_q.size(), 0);
    for (int i = 1; i < 9; i++) begin
      if (i < strobe_cyc.size()) check_eq("t2_spacing", strobe_cyc[i] - strobe_cyc[i-1], 100);
    end

    // 3: false start of three clocks
    base_rx = rx_cnt;
    base_fe = fe_cnt;
    iRx = 1'b0;
    repeat (3) @(negedge iCLK);
    iRx = 1'b1;
    check_eq("t3_busy_hi", {31'h0, oBusy}, 32'h1);
    repeat (7) @(negedge iCLK);
    check_eq("t3_busy_lo", {31'h0, oBusy}, 32'h0);
    check_eq("t3_state", {29'h0, o_dbg_state}, 32'h0);
    repeat (20) @(negedge iCLK);
    check_eq("t3_no_rx", rx_cnt - base_rx, 0);
    check_eq("t3_no_ferr", fe_cnt - base_fe, 0);
    exp_q.push_back(8'hE0);
    send_byte(8'hE0, 1'b1);
    send_bit(1'b1);
    check_eq("t3_drained", exp_q.size(), 0);
    check_eq("t3_data", {24'h0, oData}, 32'hE0);

    // 4: bad stop bit, then a line held low
    base_rx = rx_cnt;
    base_fe = fe_cnt;
    send_byte(8'h7A, 1'b0);
    repeat (50) @(negedge iCLK);
    iRx = 1'b1;
    repeat (2 * CPB) @(negedge iCLK);
    check_eq("t4_one_ferr", fe_cnt - base_fe, 1);
    check_eq("t4_no_rx", rx_cnt - base_rx, 0);
    check_eq("t4_data_held", {24'h0, oData}, 32'hE0);
    check_eq("t4_busy", {31'h0, oBusy}, 32'h0);
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_bit(1'b1);
    check_eq("t4_drained", exp_q.size(), 0);
    check_eq("t4_data", {24'h0, oData}, 32'h11);

    // 5: reset in the middle of bit 4
    base_rx = rx_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c1[i]);
    iRx = c1[4];
    repeat (5) @(negedge iCLK);
    iRst_n = 1'b0;
    #1;
    check_eq("t5_busy", {31'h0, oBusy}, 32'h0);
    check_eq("t5_data", {24'h0, oData}, 32'h00);
    check_eq("t5_ready", {31'h0, oRx_ready}, 32'h0);
    check_eq("t5_ferr", {31'h0, oFrame_err}, 32'h0);
    @(negedge iCLK);
    iRx = 1'b1;
    repeat (2) @(negedge iCLK);
    iRst_n = 1'b1;
    repeat (5) @(negedge iCLK);
    check_eq("t5_no_rx", rx_cnt - base_rx, 0);
    exp_q.push_back(8'h4B);
    send_byte(8'h4B, 1'b1);
    send_bit(1'b1);
    check_eq("t5_rx", rx_cnt - base_rx, 1);
    check_eq("t5_drained", exp_q.size(), 0);
    check_eq("t5_data_4b", {24'h0, oData}, 32'h4B);

    // 6: one-clock inverted glitch at the bit-2 sampling point
    exp_q.push_back(GLITCH_EXP);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        iRx = g[i];
        repeat (5) @(negedge iCLK);
        iRx = ~g[i];
        @(negedge iCLK);
        iRx = g[i];
        repeat (4) @(negedge iCLK);
      end else begin
        send_bit(g[i]);
      end
    end
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("t6_drained", exp_q.size(), 0);
    check_eq("t6_data", {24'h0, oData}, {24'h0, GLITCH_EXP});

    // strobe rules across the whole run
    check_eq("strobe_rules", viol, 0);
    check_eq("extra_strobes", rx_extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
